// File: rtl/barrett_stream_ctrl.sv
// -----------------------------------------------------------------------------
// barrett_stream_ctrl
//
// Stream-side controller for the barrett_pipelined reducer. It holds the
// modulus m and the precomputed Barrett mu. It accepts operands x on an input
// stream and issues at most one x per cycle to the reducer. Reducer results
// are collected into an in-order buffer and presented on an output stream.
//
// The reducer cannot be stalled. The controller therefore accepts an operand
// only while a buffer slot is guaranteed for it. The occupied counter tracks
// operands that are accepted but not yet consumed at the output, whether they
// are in the reducer or already buffered. It never exceeds DEPTH.
//
// Handshake rule (both streams): a transfer happens on a rising clk_i edge
// where valid and ready are both high. Ready never depends on the valid of
// the same stream. A valid producer holds its data until the transfer.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   cfg_load_i     one-cycle pulse that loads cfg_m_i / cfg_mu_i
//   cfg_m_i        modulus
//   cfg_mu_i       precomputed Barrett mu
//   in_valid_i     operand valid
//   in_ready_o     operand accepted when in_valid_i & in_ready_o
//   in_x_i         operand x
//   red_start_o    reducer start_i
//   red_x_o        reducer x_i
//   red_m_o        reducer m_i (held register)
//   red_mu_o       reducer mu_i (held register)
//   red_result_i   reducer result_o
//   red_valid_i    reducer valid_o
//   out_valid_o    result valid (buffer non-empty)
//   out_ready_i    result consumed when out_valid_o & out_ready_i
//   out_data_o     x mod m, in acceptance order
//   busy_o         work in flight, buffered, or being issued
//   err_o          sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module barrett_stream_ctrl #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_load_i,
    input  logic [WIDTH-1:0] cfg_m_i,
    input  logic [WIDTH-1:0] cfg_mu_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_x_i,
    output logic             red_start_o,
    output logic [WIDTH-1:0] red_x_o,
    output logic [WIDTH-1:0] red_m_o,
    output logic [WIDTH-1:0] red_mu_o,
    input  logic [WIDTH-1:0] red_result_i,
    input  logic             red_valid_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int CW   = $clog2(DEPTH + 1);
    // At most LATENCY reductions overlap inside the reducer. Credits also cap
    // them at DEPTH.
    localparam int IMAX = (LATENCY < DEPTH) ? LATENCY : DEPTH;
    localparam int IW   = $clog2(IMAX + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        S_UNCFG = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] mu_q;
    logic [WIDTH-1:0] x_q;
    logic             start_q;
    logic [CW-1:0]    occupied_q;
    logic [IW-1:0]    inflight_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic             err_q;

    logic in_hs;
    logic out_hs;
    logic buf_empty;
    logic buf_full;
    logic red_known;
    logic red_stray;
    logic buf_we;
    logic buf_overflow;
    logic cfg_err;

    // Pointers carry one extra wrap bit. Equal pointers mean empty. Pointers
    // that differ only in the wrap bit mean full.
    assign buf_empty = (wr_ptr_q == rd_ptr_q);
    assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign busy_o      = (inflight_q != '0) | ~buf_empty | start_q;
    assign in_ready_o  = (state_q == S_RUN) & ~cfg_load_i & (occupied_q < DEPTH_C);
    assign in_hs       = in_valid_i & in_ready_o;
    assign out_valid_o = ~buf_empty;
    assign out_data_o  = buf_q[rd_ptr_q[AW-1:0]];
    assign out_hs      = out_valid_o & out_ready_i;

    assign red_start_o = start_q;
    assign red_x_o     = x_q;
    assign red_m_o     = m_q;
    assign red_mu_o    = mu_q;
    assign err_o       = err_q;

    // A reducer result is legitimate only if a reduction is outstanding. A
    // result that arrives after a reset abandoned its reduction is discarded.
    assign red_known    = red_valid_i & (inflight_q != '0);
    assign red_stray    = red_valid_i & (inflight_q == '0);
    assign buf_we       = red_known & ~buf_full;
    assign buf_overflow = red_known & buf_full;
    // Changing m/mu under in-flight work would corrupt those results.
    assign cfg_err      = (state_q == S_RUN) & cfg_load_i & busy_o;

    // Configuration FSM. It holds the modulus registers that feed the reducer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_UNCFG;
            m_q     <= '0;
            mu_q    <= '0;
        end else begin
            case (state_q)
                S_UNCFG: begin
                    if (cfg_load_i) begin
                        m_q     <= cfg_m_i;
                        mu_q    <= cfg_mu_i;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cfg_load_i && !busy_o) begin
                        m_q  <= cfg_m_i;
                        mu_q <= cfg_mu_i;
                    end
                end
                default: state_q <= S_UNCFG;
            endcase
        end
    end

    // Issue register, credit/inflight counters, buffer pointers, error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q    <= 1'b0;
            x_q        <= '0;
            occupied_q <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            start_q <= in_hs;
            if (in_hs) begin
                x_q <= in_x_i;
            end

            if (in_hs && !out_hs) begin
                occupied_q <= occupied_q + CW'(1);
            end else if (!in_hs && out_hs) begin
                occupied_q <= occupied_q - CW'(1);
            end

            if (start_q && !red_known) begin
                inflight_q <= inflight_q + IW'(1);
            end else if (!start_q && red_known) begin
                inflight_q <= inflight_q - IW'(1);
            end

            if (buf_we) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (out_hs) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            if (cfg_err || red_stray || buf_overflow) begin
                err_q <= 1'b1;
            end
        end
    end

    // Result storage. The head entry is read directly, so the first word is
    // visible as soon as it is written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            buf_q[wr_ptr_q[AW-1:0]] <= red_result_i;
        end
    end

endmodule

// File: tb/tb_barrett_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_barrett_stream_ctrl
//
// Directed bench for barrett_stream_ctrl. A behavioural reducer returns
// x mod m exactly LATENCY cycles after start. It is not reset by rst_n, so
// results launched before a reset still arrive after it. A monitor collects
// every output transfer into got_q. Each scenario task compares against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_barrett_stream_ctrl;

    localparam int WIDTH   = 64;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
    localparam logic [63:0] M  = 64'h3A32E4C4C7A8C21B;
    localparam logic [63:0] MU = 64'h466123E72A6BDD53;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             cfg_load = 1'b0;
    logic [WIDTH-1:0] cfg_m    = '0;
    logic [WIDTH-1:0] cfg_mu   = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_x     = '0;
    logic             red_start;
    logic [WIDTH-1:0] red_x;
    logic [WIDTH-1:0] red_m;
    logic [WIDTH-1:0] red_mu;
    logic [WIDTH-1:0] red_result;
    logic             red_valid;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] exp_q[$];

    barrett_stream_ctrl #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg_load_i  (cfg_load),
        .cfg_m_i     (cfg_m),
        .cfg_mu_i    (cfg_mu),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_x_i      (in_x),
        .red_start_o (red_start),
        .red_x_o     (red_x),
        .red_m_o     (red_m),
        .red_mu_o    (red_mu),
        .red_result_i(red_result),
        .red_valid_i (red_valid),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy),
        .err_o       (err)
    );

    // ---------------- reducer model ----------------
    logic [LATENCY-1:0] rm_v = '0;
    logic [WIDTH-1:0]   rm_d [LATENCY];

    initial begin
        for (int k = 0; k < LATENCY; k++) rm_d[k] = '0;
    end

    always @(posedge clk) begin
        rm_v    <= {rm_v[LATENCY-2:0], red_start};
        rm_d[0] <= (red_m != '0) ? (red_x % red_m) : '0;
        for (int k = 1; k < LATENCY; k++) rm_d[k] <= rm_d[k-1];
    end

    assign red_valid  = rm_v[LATENCY-1];
    assign red_result = rm_d[LATENCY-1];

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) got_q.push_back(out_data);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cfg(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] mu);
        @(negedge clk);
        cfg_load = 1'b1;
        cfg_m    = m;
        cfg_mu   = mu;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int c = 0; c < 60 && got_q.size() < n; c++) @(negedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready, red_start, out_valid, busy, err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {in_ready, red_start, out_valid, busy, err});
        end
        n_checks++;
        if ({red_x, red_m, red_mu, out_data} !== 256'b0) begin
            n_fail++; $display("FAIL reset_data: got x=%h m=%h mu=%h d=%h expected zeros", red_x, red_m, red_mu, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL uncfg_ready: got %b expected 0", in_ready);
        end
    endtask

    task automatic test_single();
        int lat;
        drive_cfg(M, MU);
        got_q.delete();
        #1;
        n_checks++;
        if (red_m !== M || red_mu !== MU) begin
            n_fail++; $display("FAIL cfg_load: got m=%h mu=%h expected m=%h mu=%h", red_m, red_mu, M, MU);
        end
        @(negedge clk);
        in_valid = 1'b1; in_x = 64'h1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (red_start !== 1'b1 || red_x !== 64'h1) begin
            n_fail++; $display("FAIL single_issue: got start=%b x=%h expected start=1 x=1", red_start, red_x);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== LATENCY + 2) begin
            n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, LATENCY + 2);
        end
        n_checks++;
        if (out_data !== 64'h1) begin
            n_fail++; $display("FAIL single_data: got %h expected 1", out_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || got_q.size() !== 1) begin
            n_fail++; $display("FAIL single_drain: got valid=%b busy=%b n=%0d expected 0 0 1", out_valid, busy, got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] xs [4];
        xs[0] = 64'h3A32E4C4C7A8C21B;
        xs[1] = 64'h3A32E4C4C7A8C220;
        xs[2] = 64'h7465C9898F518436;
        xs[3] = 64'hFFFFFFFFFFFFFFFF;
        exp_q.delete();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h5);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h17346CECE15CF793);
        // An idle reload with in_valid high must block input for that cycle.
        @(negedge clk);
        cfg_load = 1'b1; cfg_m = M; cfg_mu = MU; in_valid = 1'b1; in_x = 64'h5; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL cfg_blocks_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b0;
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = xs[i];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_results(4);
        n_checks++;
        if (got_q.size() !== 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_err: got %b expected 0", err);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        got_q.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_x = M + 64'(acc);
            #1;
            if (in_ready) acc++;
        end
        n_checks++;
        if (acc !== DEPTH || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: got %0d ready=%b expected %0d ready=0", acc, in_ready, DEPTH);
        end
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d outputs expected 0", got_q.size());
        end
        for (int c = 0; c < 80 && got_q.size() < 12; c++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = (acc < 12); in_x = M + 64'(acc);
            #1;
            if (in_valid && in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (acc !== 12 || got_q.size() !== 12) begin
            n_fail++; $display("FAIL bp_count: got acc=%0d out=%0d expected 12 12", acc, got_q.size());
        end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 64'(i)) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_q[i], 64'(i));
            end
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL bp_err: got %b expected 0", err);
        end
    endtask

    task automatic test_cfg_while_busy();
        got_q.delete();
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_x = M + 64'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL busy_send[%0d]: got %b expected 1", i, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_load = 1'b1; cfg_m = 64'h1234; cfg_mu = 64'h5;
        #1;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL busy_cfg_cycle: got busy=%b ready=%b expected 1 0", busy, in_ready);
        end
        @(negedge clk);
        cfg_load = 1'b0;
        #1;
        n_checks++;
        if (red_m !== M || red_mu !== MU || err !== 1'b1) begin
            n_fail++; $display("FAIL busy_cfg_ignored: got m=%h mu=%h err=%b expected m=%h mu=%h err=1", red_m, red_mu, err, M, MU);
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_results(2);
        n_checks++;
        if (got_q.size() !== 2 || got_q[0] !== 64'h1 || got_q[1] !== 64'h2) begin
            n_fail++; $display("FAIL busy_results: got n=%0d expected results 1,2 under old m", got_q.size());
        end
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_reset_mid_burst();
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_x = M + 64'(3 + i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL mid_send[%0d]: got %b expected 1", i, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, red_start, out_valid, busy, err} !== 5'b0) begin
            n_fail++; $display("FAIL mid_reset_ctrl: got %b expected 00000", {in_ready, red_start, out_valid, busy, err});
        end
        n_checks++;
        if ({red_x, red_m, red_mu, out_data} !== 256'b0) begin
            n_fail++; $display("FAIL mid_reset_data: got x=%h m=%h mu=%h d=%h expected zeros", red_x, red_m, red_mu, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || got_q.size() !== 0) begin
            n_fail++; $display("FAIL stray_results: got err=%b valid=%b busy=%b n=%0d expected 1 0 0 0", err, out_valid, busy, got_q.size());
        end
        drive_cfg(M, MU);
        got_q.delete();
        @(negedge clk);
        in_valid = 1'b1; in_x = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        in_x = 64'h7465C9898F518436;
        @(negedge clk);
        in_valid = 1'b0;
        wait_results(2);
        n_checks++;
        if (got_q.size() !== 2 || got_q[0] !== 64'h17346CECE15CF793 || got_q[1] !== 64'h0) begin
            n_fail++; $display("FAIL post_reset_stream: got n=%0d expected 17346cece15cf793,0", got_q.size());
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_err: got %b expected 1", err);
        end
    endtask

    task automatic test_unconfigured();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = 64'h5;
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || red_start !== 1'b0) begin
                n_fail++; $display("FAIL uncfg_hold[%0d]: got ready=%b start=%b expected 0 0", c, in_ready, red_start);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_cfg_while_busy();
        test_reset_mid_burst();
        test_unconfigured();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrett_stream_ctrl.md
Name: barrett_stream_ctrl

Overview:
Stream-side controller for barrett_pipelined. It accepts operands over a valid/ready input stream, holds the modulus m and precomputed mu, and issues one x per cycle to the reducer. It collects each result_o/valid_o pulse into an in-order result buffer and presents results on a valid/ready output stream. Credit-based issue guarantees every in-flight reduction has a buffer slot, because the reducer has no backpressure.

Parameters:
WIDTH, 64, operand/modulus/result width
LATENCY, 4, reducer latency in cycles from start_i high to matching valid_o high (must be >= 1)
DEPTH, 8, result buffer entries (power of two; DEPTH >= LATENCY+2 for full throughput)

Ports:
clk_i  in  1  rising-edge clock
rst_ni  in  1  reset, asynchronous, active-low
cfg_load_i  in  1  load m/mu (one-cycle pulse)
cfg_m_i  in  WIDTH  modulus
cfg_mu_i  in  WIDTH  precomputed Barrett mu
in_valid_i  in  1  operand valid
in_ready_o  out  1  operand accepted when in_valid_i & in_ready_o
in_x_i  in  WIDTH  operand x
red_start_o  out  1  to reducer start_i
red_x_o  out  WIDTH  to reducer x_i
red_m_o  out  WIDTH  to reducer m_i (held register)
red_mu_o  out  WIDTH  to reducer mu_i (held register)
red_result_i  in  WIDTH  from reducer result_o
red_valid_i  in  1  from reducer valid_o
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when out_valid_o & out_ready_i
out_data_o  out  WIDTH  x mod m, in input order
busy_o  out  1  inflight != 0 or buffer non-empty or red_start_o
err_o  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (async, rst_ni low):
  - All outputs go to 0: in_ready_o, red_start_o, red_x_o, red_m_o, red_mu_o, out_valid_o, out_data_o, busy_o, err_o.
  - State goes to S_UNCFG; counters and buffer pointers clear.
  - Any in-flight reductions are abandoned.
- FSM:
  - S_UNCFG: in_ready_o = 0. A cfg_load_i pulse registers m/mu, then -> S_RUN.
  - S_RUN: cfg_load_i while busy_o = 1 is ignored and sets err_o. cfg_load_i while idle reloads m/mu the next cycle and stays in S_RUN.
  - The cycle of cfg_load_i forces in_ready_o = 0.
- occupied counter (0..DEPTH): +1 on input handshake, -1 on output handshake. Both in the same cycle leave it unchanged.
- in_ready_o = (state == S_RUN) & !cfg_load_i & (occupied < DEPTH). Combinational from registers and cfg_load_i only; it does not depend on in_valid_i.
- Issue: an input handshake in cycle t gives red_start_o = 1 and red_x_o = in_x_i in cycle t+1 (registered). With no handshake, red_start_o = 0 and red_x_o holds its value.
- inflight counter: +1 when red_start_o is high, -1 on red_valid_i; simultaneous events net to zero.
- Unexpected result: red_valid_i with inflight == 0 (e.g. after reset mid-operation) discards the data and sets err_o.
- Buffer write: on red_valid_i, write red_result_i at the write pointer.
  - If the buffer is already full, set err_o and drop the data. This is unreachable under correct credits and is a verification check.
- Output: out_valid_o = buffer non-empty; out_data_o = head entry (registered storage, first-word visible).
  - Latency from input handshake to out_valid_o is LATENCY+2 cycles with an empty buffer.
  - Simultaneous write and read of a non-empty buffer is permitted.
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- Throughput: 1 operand/cycle sustained when out_ready_i = 1. With out_ready_i = 0, at most DEPTH operands are accepted, then in_ready_o drops.
- Ordering: results leave strictly in acceptance order.

Test Plan:
1. Reset, load m=0x3A32E4C4C7A8C21B, mu=0x466123E72A6BDD53, send x=0x1 -> out_data_o=0x1 exactly LATENCY+2 cycles after the handshake.
2. Back-to-back burst x = 0x3A32E4C4C7A8C21B, 0x3A32E4C4C7A8C220, 0x7465C9898F518436, 0xFFFFFFFFFFFFFFFF with out_ready_i=1:
   - Required results in order: 0x0, 0x5, 0x0, 0x17346CECE15CF793.
   - in_ready_o stays high throughout.
3. Hold out_ready_i=0 and stream 12 operands:
   - Exactly DEPTH=8 are accepted, then in_ready_o=0.
   - Releasing out_ready_i drains 8 results in order, then the remaining 4 are accepted; err_o stays 0.
4. Pulse cfg_load_i while busy_o=1 -> m/mu unchanged, err_o=1 and held until reset.
5. Pulse rst_ni low mid-burst with 3 results in flight -> all outputs 0 immediately. Reducer valid_o pulses arriving after reset are ignored with err_o set; the next configured stream produces correct results.
6. Before any cfg_load_i, hold in_valid_i=1 -> in_ready_o=0 and red_start_o=0 for 20 cycles.
